// File: rtl/if_id_pkg.sv
// Shared types for the fetch-to-decode buffer: entry layout, occupancy
// states and the default NOP instruction word.
package if_id_pkg;

    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] next_pc;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } buf_state_e;

    // Occupancy state from an entry count.
    function automatic buf_state_e stateOf(input int cnt, input int depth);
        if (cnt == 0)
            return EMPTY;
        else if (cnt >= depth)
            return FULL;
        else
            return PARTIAL;
    endfunction

endpackage

// File: rtl/if_id_entry_ram.sv
// DEPTH-entry storage for the fetch-to-decode buffer: one synchronous write
// port, one asynchronous read port.
module if_id_entry_ram
    import if_id_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         wrEn,
    input  logic [AW-1:0] wrAddr,
    input  if_id_entry_t wrData,
    input  logic [AW-1:0] rdAddr,
    output if_id_entry_t rdData
);

    if_id_entry_t mem [DEPTH];

    // Write the incoming entry into its slot; contents need no reset because
    // occupancy is tracked by the controller.
    always_ff @(posedge clk) begin
        if (wrEn)
            mem[wrAddr] <= wrData;
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode pipeline buffer: in-order DEPTH-entry queue with a
// valid/ready handshake on each side, bubble drop and flush.
// Optional performance counters are enabled with IF_ID_BUFFER_PERF_EN.
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_next_pc,
    input  logic        in_bubble,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_imm,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc
`ifdef IF_ID_BUFFER_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] count, nextCount;
    logic [AW-1:0] rdPtr, nextRd;
    logic [AW-1:0] wrPtr, nextWr;
    logic          push, pop;
    buf_state_e    nextState;
    if_id_entry_t  inWord, ramRd, headData;

    if_id_entry_ram #(.DEPTH(DEPTH)) uRam (
        .clk    (clk),
        .wrEn   (push),
        .wrAddr (wrPtr),
        .wrData (inWord),
        .rdAddr (nextRd),
        .rdData (ramRd)
    );

    // Handshake, pointer/count next-state and the entry that will be at the
    // head after this edge (bypassing the RAM when that slot is being written).
    always_comb begin
        inWord    = '{instr: in_instr, imm: in_imm, pc: in_pc, next_pc: in_next_pc};
        push      = in_valid & in_ready & ~in_bubble & ~flush;
        pop       = out_valid & out_ready & ~flush;
        nextRd    = pop  ? rdPtr + 1'b1 : rdPtr;
        nextWr    = push ? wrPtr + 1'b1 : wrPtr;
        nextCount = count;
        case ({push, pop})
            2'b10:   nextCount = count + 1'b1;
            2'b01:   nextCount = count - 1'b1;
            default: nextCount = count;
        endcase
        if (flush) begin
            nextCount = '0;
            nextRd    = '0;
            nextWr    = '0;
        end
        nextState = stateOf(int'(nextCount), DEPTH);
        // The written slot becomes the head only when the queue would
        // otherwise be empty after this edge.
        headData  = (push && (wrPtr == nextRd)) ? inWord : ramRd;
    end

    // Control state and registered outputs; imm/pc/next_pc hold when empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count       <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_instr   <= NOP_INSTR;
            out_imm     <= '0;
            out_pc      <= '0;
            out_next_pc <= '0;
        end else begin
            count    <= nextCount;
            rdPtr    <= nextRd;
            wrPtr    <= nextWr;
            in_ready <= (nextState != FULL);
            if (nextState == EMPTY) begin
                out_valid <= 1'b0;
                out_instr <= NOP_INSTR;
            end else begin
                out_valid   <= 1'b1;
                out_instr   <= headData.instr;
                out_imm     <= headData.imm;
                out_pc      <= headData.pc;
                out_next_pc <= headData.next_pc;
            end
        end
    end

`ifdef IF_ID_BUFFER_PERF_EN
    // Saturating counters for fetch back-pressure cycles and flush cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed vector table, reset and
// perf sequences, then randomized traffic against a queue reference model.
module tb_if_id_buffer;
    import if_id_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_bubble, flush;
    logic [15:0] in_instr, in_imm;
    logic [31:0] in_pc, in_next_pc;
    logic        out_valid, out_ready;
    logic [15:0] out_instr, out_imm;
    logic [31:0] out_pc, out_next_pc;
`ifdef IF_ID_BUFFER_PERF_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    int errors = 0;
    int checks = 0;

    if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .in_next_pc  (in_next_pc),
        .in_bubble   (in_bubble),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_next_pc (out_next_pc)
`ifdef IF_ID_BUFFER_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic f, input logic r,
                         input logic [31:0] pc);
        logic [7:0] lo;
        lo         = pc[7:0];
        in_valid   = v;
        in_bubble  = b;
        flush      = f;
        out_ready  = r;
        in_pc      = pc;
        in_instr   = {8'hC0, lo};
        in_imm     = {8'h1D, lo};
        in_next_pc = pc + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v, b, f, r;
        logic [31:0] pc;
        logic        expValid, expReady;
        logic [31:0] expPc;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic b, input logic f, input logic r,
                                input logic [31:0] pc, input logic ev, input logic er,
                                input logic [31:0] ep);
        vec_t t;
        t.v = v; t.b = b; t.f = f; t.r = r; t.pc = pc;
        t.expValid = ev; t.expReady = er; t.expPc = ep;
        return t;
    endfunction

    // Reference model state: queue of held entries and the last head shown.
    if_id_entry_t q[$];
    if_id_entry_t lastHead;

    initial begin
        vec_t vecs[20];
        logic [7:0] lo;

        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h99);

        // Reset held two cycles while fetch offers a word.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", out_valid, 1'b0);
            check("rst_instr", out_instr, 16'h0000);
            check("rst_pc", out_pc, 32'h0);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_ready", in_ready, 1'b1);
        tick();
        check("post_rst_valid", out_valid, 1'b0);
        check("post_rst_imm", out_imm, 16'h0);

        // streaming
        vecs[0]  = mk(1, 0, 0, 1, 32'h20, 1, 1, 32'h20);
        vecs[1]  = mk(1, 0, 0, 1, 32'h21, 1, 1, 32'h21);
        vecs[2]  = mk(1, 0, 0, 1, 32'h22, 1, 1, 32'h22);
        vecs[3]  = mk(0, 0, 0, 1, 32'h00, 0, 1, 32'h22);
        // stall to FULL, extra word offered while FULL
        vecs[4]  = mk(1, 0, 0, 0, 32'h30, 1, 1, 32'h30);
        vecs[5]  = mk(1, 0, 0, 0, 32'h31, 1, 0, 32'h30);
        vecs[6]  = mk(1, 0, 0, 0, 32'h32, 1, 0, 32'h30);
        vecs[7]  = mk(1, 0, 0, 1, 32'h32, 1, 1, 32'h31);
        vecs[8]  = mk(1, 0, 0, 1, 32'h32, 1, 1, 32'h32);
        vecs[9]  = mk(0, 0, 0, 1, 32'h00, 0, 1, 32'h32);
        // flush with two held entries and a word on the flush cycle
        vecs[10] = mk(1, 0, 0, 0, 32'h3A, 1, 1, 32'h3A);
        vecs[11] = mk(1, 0, 0, 0, 32'h3B, 1, 0, 32'h3A);
        vecs[12] = mk(1, 0, 1, 1, 32'h40, 0, 1, 32'h3A);
        vecs[13] = mk(0, 0, 0, 1, 32'h00, 0, 1, 32'h3A);
        // bubbles between two real words
        vecs[14] = mk(1, 0, 0, 0, 32'h50, 1, 1, 32'h50);
        vecs[15] = mk(1, 1, 0, 0, 32'h55, 1, 1, 32'h50);
        vecs[16] = mk(1, 1, 0, 0, 32'h56, 1, 1, 32'h50);
        vecs[17] = mk(1, 0, 0, 0, 32'h51, 1, 0, 32'h50);
        vecs[18] = mk(0, 0, 0, 1, 32'h00, 1, 1, 32'h51);
        vecs[19] = mk(0, 0, 0, 1, 32'h00, 0, 1, 32'h51);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].b, vecs[i].f, vecs[i].r, vecs[i].pc);
            tick();
            lo = vecs[i].expPc[7:0];
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].expValid);
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].expReady);
            check($sformatf("vec%0d_pc", i), out_pc, vecs[i].expPc);
            check($sformatf("vec%0d_instr", i), out_instr,
                  vecs[i].expValid ? {8'hC0, lo} : 16'h0000);
            check($sformatf("vec%0d_imm", i), out_imm, {8'h1D, lo});
            check($sformatf("vec%0d_npc", i), out_next_pc, vecs[i].expPc + 32'd4);
        end

        // Reset in the middle of operation with an entry held.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h60);
        tick();
        check("mid_pre_valid", out_valid, 1'b1);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h61);
        tick();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_pc", out_pc, 32'h0);
        check("mid_rst_imm", out_imm, 16'h0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("mid_post_ready", in_ready, 1'b1);
        check("mid_post_valid", out_valid, 1'b0);

`ifdef IF_ID_BUFFER_PERF_EN
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h70); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h71); tick();
        check("perf_full", in_ready, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h72);
        for (int i = 0; i < 3; i++) tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        check("perf_stall", stall_cycles, 16'd3);
        check("perf_flush", flush_count, 16'd2);
        rst = 1'b0; tick(); rst = 1'b1;
        check("perf_rst_stall", stall_cycles, 16'd0);
        check("perf_rst_flush", flush_count, 16'd0);
`endif

        // Randomized traffic against the queue model, starting from reset.
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        q.delete();
        lastHead = '0;
        for (int n = 0; n < 600; n++) begin
            if_id_entry_t w;
            int sizeBefore;
            rst        = ($urandom_range(0, 149) != 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_bubble  = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_instr   = 16'($urandom);
            in_imm     = 16'($urandom);
            in_pc      = $urandom;
            in_next_pc = $urandom;
            w = '{instr: in_instr, imm: in_imm, pc: in_pc, next_pc: in_next_pc};

            // Queue semantics applied with the pre-edge occupancy.
            sizeBefore = q.size();
            if (!rst) begin
                q.delete();
                lastHead = '0;
            end else if (flush) begin
                q.delete();
            end else begin
                if (out_ready && sizeBefore > 0) void'(q.pop_front());
                if (in_valid && !in_bubble && sizeBefore < DEPTH) q.push_back(w);
            end
            if (q.size() > 0) lastHead = q[0];

            tick();
            check("rnd_valid", out_valid, q.size() > 0);
            check("rnd_ready", in_ready, q.size() < DEPTH);
            check("rnd_instr", out_instr, (q.size() > 0) ? q[0].instr : 16'h0000);
            check("rnd_imm", out_imm, lastHead.imm);
            check("rnd_pc", out_pc, lastHead.pc);
            check("rnd_npc", out_next_pc, lastHead.next_pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
